// File: rtl/tpu_host_driver.sv
// Host-side driver for the small TPU: loads 8 operand bytes, waits for done
// (bounded by TIMEOUT_CYCLES), reads back 8 result bytes and offers one response.
module tpu_host_driver #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [63:0] cmd_data,
   input  logic        cmd_transpose,
   input  logic        cmd_activation,
   output logic [7:0]  tpu_ui_in,
   output logic [7:0]  tpu_uio_in,
   input  logic [7:0]  tpu_uo_out,
   input  logic [7:0]  tpu_uio_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_timeout,
   output logic        busy
);

   localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_DONE,
      READ,
      RESP
   } state_t;

   state_t              state;
   logic [2:0]          byte_idx;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [63:0]         cmd_q;
   logic                transpose_q;
   logic                activation_q;
   logic                flags_on;
   logic                done;
   logic                unused_status;

   assign done          = tpu_uio_out[7];
   assign unused_status = ^tpu_uio_out[6:0];

   // Flags accompany the command from the first LOAD byte through the last READ byte.
   assign flags_on   = (state == LOAD) || (state == WAIT_DONE) || (state == READ);
   assign cmd_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign tpu_ui_in  = (state == LOAD) ? cmd_q[{byte_idx, 3'b000} +: 8] : 8'h00;
   assign tpu_uio_in = {5'b00000, activation_q & flags_on, transpose_q & flags_on,
                        state == LOAD};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         byte_idx     <= 3'd0;
         wait_cnt     <= '0;
         cmd_q        <= 64'd0;
         transpose_q  <= 1'b0;
         activation_q <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_timeout  <= 1'b0;
         rsp_data     <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_q        <= cmd_data;
                  transpose_q  <= cmd_transpose;
                  activation_q <= cmd_activation;
                  byte_idx     <= 3'd0;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               byte_idx <= byte_idx + 3'd1;
               if (byte_idx == 3'd7) begin
                  wait_cnt <= '0;
                  state    <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               // A done seen on the final allowed cycle still beats the timeout.
               if (done) begin
                  rsp_data[7:0] <= tpu_uo_out;
                  byte_idx      <= 3'd1;
                  state         <= READ;
               end else if (wait_cnt == WAIT_LAST) begin
                  rsp_data    <= 64'd0;
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b1;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            READ: begin
               rsp_data[{byte_idx, 3'b000} +: 8] <= tpu_uo_out;
               byte_idx <= byte_idx + 3'd1;
               if (byte_idx == 3'd7) begin
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b0;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  rsp_timeout <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed bench for tpu_host_driver: table of commands driven through the full
// LOAD/WAIT/READ/RESP cycle, plus reset checks including a reset in mid-READ.
module tb_tpu_host_driver;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [63:0] cmd_data;
   logic        cmd_transpose;
   logic        cmd_activation;
   logic [7:0]  tpu_ui_in;
   logic [7:0]  tpu_uio_in;
   logic [7:0]  tpu_uo_out;
   logic [7:0]  tpu_uio_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_timeout;
   logic        busy;

   always #5 clk = ~clk;

   tpu_host_driver #(.TIMEOUT_CYCLES(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_data       (cmd_data),
      .cmd_transpose  (cmd_transpose),
      .cmd_activation (cmd_activation),
      .tpu_ui_in      (tpu_ui_in),
      .tpu_uio_in     (tpu_uio_in),
      .tpu_uo_out     (tpu_uo_out),
      .tpu_uio_out    (tpu_uio_out),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_timeout    (rsp_timeout),
      .busy           (busy)
   );

   typedef struct {
      logic [63:0] data;
      logic        tr;
      logic        act;
      int          done_at;   // WAIT_DONE cycle index where done rises, -1 = never
      logic        spur;      // done held high during LOAD and READ
      logic [63:0] stream;    // byte j = TPU result byte j
      int          bp;        // cycles rsp_ready stays low
      logic        held;      // keep cmd_valid high through RESP
      logic [63:0] exp_data;
      logic        exp_to;
   } vec_t;

   vec_t vecs[5];
   int   errors = 0;
   int   checks = 0;

   task automatic report(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic chk1(input string nm, input logic a, input logic e);
      report(nm, {63'd0, a}, {63'd0, e});
   endtask

   task automatic chk8(input string nm, input logic [7:0] a, input logic [7:0] e);
      report(nm, {56'd0, a}, {56'd0, e});
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, " cmd_ready"}, cmd_ready, 1'b1);
      chk1({tag, " busy"}, busy, 1'b0);
      chk1({tag, " rsp_valid"}, rsp_valid, 1'b0);
      chk1({tag, " rsp_timeout"}, rsp_timeout, 1'b0);
      chk8({tag, " ui_in"}, tpu_ui_in, 8'h00);
      chk8({tag, " uio_in"}, tpu_uio_in, 8'h00);
      report({tag, " rsp_data"}, rsp_data, 64'd0);
   endtask

   // Called in an IDLE cycle; returns in the IDLE cycle after the response handshake.
   task automatic run_cmd(input vec_t v);
      logic got_done;
      cmd_valid      = 1'b1;
      cmd_data       = v.data;
      cmd_transpose  = v.tr;
      cmd_activation = v.act;
      chk1("accept cmd_ready", cmd_ready, 1'b1);
      step;
      cmd_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk8("load ui_in", tpu_ui_in, v.data[8*k +: 8]);
         chk8("load uio_in", tpu_uio_in, {5'b0, v.act, v.tr, 1'b1});
         chk1("load busy", busy, 1'b1);
         tpu_uio_out = {v.spur, 7'd0};
         tpu_uo_out  = 8'hEE;
         step;
      end
      got_done = 1'b0;
      for (int w = 0; w < TO; w++) begin
         chk8("wait ui_in", tpu_ui_in, 8'h00);
         chk8("wait uio_in", tpu_uio_in, {5'b0, v.act, v.tr, 1'b0});
         chk1("wait rsp_valid", rsp_valid, 1'b0);
         if (w == v.done_at) begin
            tpu_uio_out = 8'h80;
            tpu_uo_out  = v.stream[7:0];
            got_done    = 1'b1;
            step;
            break;
         end
         tpu_uio_out = 8'h00;
         step;
      end
      if (got_done) begin
         for (int j = 1; j < 8; j++) begin
            chk8("read uio_in", tpu_uio_in, {5'b0, v.act, v.tr, 1'b0});
            chk1("read rsp_valid", rsp_valid, 1'b0);
            tpu_uo_out  = v.stream[8*j +: 8];
            tpu_uio_out = {v.spur, 7'd0};
            step;
         end
      end
      tpu_uio_out = 8'h00;
      for (int b = 0; b <= v.bp; b++) begin
         chk1("resp rsp_valid", rsp_valid, 1'b1);
         chk1("resp rsp_timeout", rsp_timeout, v.exp_to);
         report("resp rsp_data", rsp_data, v.exp_data);
         chk8("resp uio_in", tpu_uio_in, 8'h00);
         chk1("resp cmd_ready", cmd_ready, 1'b0);
         chk1("resp busy", busy, 1'b1);
         rsp_ready = (b == v.bp);
         cmd_valid = v.held;
         step;
      end
      rsp_ready = 1'b0;
      chk1("post rsp_valid", rsp_valid, 1'b0);
      chk1("post cmd_ready", cmd_ready, 1'b1);
      chk1("post busy", busy, 1'b0);
      report("post rsp_data retained", rsp_data, v.exp_data);
   endtask

   initial begin
      vecs[0] = '{64'h0807_0605_0100_0001, 1'b0, 1'b0, 2, 1'b0,
                  64'h0008_0007_0006_0005, 0, 1'b0, 64'h0008_0007_0006_0005, 1'b0};
      vecs[1] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 0, 1'b0,
                  64'h8877_6655_4433_2211, 10, 1'b1, 64'h8877_6655_4433_2211, 1'b0};
      vecs[2] = '{64'hCAFE_F00D_0102_0304, 1'b1, 1'b0, -1, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
      vecs[3] = '{64'h0F0E_0D0C_0B0A_0908, 1'b0, 1'b1, 0, 1'b1,
                  64'hA8A7_A6A5_A4A3_A2A1, 1, 1'b0, 64'hA8A7_A6A5_A4A3_A2A1, 1'b0};
      vecs[4] = '{64'h5555_AAAA_3333_CCCC, 1'b0, 1'b0, TO - 1, 1'b0,
                  64'h6745_2301_EFBE_ADDE, 0, 1'b0, 64'h6745_2301_EFBE_ADDE, 1'b0};

      rst_n          = 1'b0;
      cmd_valid      = 1'b0;
      cmd_data       = 64'd0;
      cmd_transpose  = 1'b0;
      cmd_activation = 1'b0;
      tpu_uo_out     = 8'h00;
      tpu_uio_out    = 8'h00;
      rsp_ready      = 1'b0;
      #1;
      chk_reset_outputs("reset");
      step;
      step;
      rst_n = 1'b1;
      step;
      chk_reset_outputs("after reset");

      for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

      // Reset while READ has captured three bytes.
      cmd_valid      = 1'b1;
      cmd_data       = 64'h7766_5544_3322_1100;
      cmd_transpose  = 1'b1;
      cmd_activation = 1'b1;
      step;
      cmd_valid = 1'b0;
      for (int k = 0; k < 8; k++) step;
      tpu_uio_out = 8'h80;
      tpu_uo_out  = 8'h31;
      step;
      tpu_uo_out = 8'h32;
      step;
      tpu_uo_out = 8'h33;
      step;
      chk8("midread uio_in", tpu_uio_in, 8'h06);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midread reset");
      step;
      step;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step;
         chk1("post-reset rsp_valid", rsp_valid, 1'b0);
         chk1("post-reset cmd_ready", cmd_ready, 1'b1);
      end
      tpu_uio_out = 8'h00;
      run_cmd(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
